// File: rtl/inst_fetch_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch arbiter.
package inst_fetch_arbiter_pkg;

    localparam int unsigned IfArbWaitMax = 4;
    localparam int unsigned IfArbCntW    = 4;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IfArbIdle    = 2'b00,
        IfArbRespIf  = 2'b01,
        IfArbRespDbg = 2'b10
    } if_arb_state_e;

    // Word accesses only; any nonzero byte offset is a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_arbiter.sv
// Two-port instruction ROM arbiter: IF fetch port has priority, the debug port
// is guaranteed service after WAIT_LIMIT consecutive lost arbitration cycles.
module inst_fetch_arbiter
    import inst_fetch_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAIT_LIMIT = IfArbWaitMax
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_inst,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data,
    output logic              misalign,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq
);

    localparam logic [IfArbCntW-1:0] WaitLimitC = IfArbCntW'(WAIT_LIMIT);
    localparam logic [DATA_W-1:0]    ZeroData   = DATA_W'(ZeroWord);

    if_arb_state_e        state_q, state_d;
    logic [IfArbCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]    resp_word_q, resp_word_d;
    logic                 resp_mis_q, resp_mis_d;
    logic                 grant_if, grant_dbg;
    logic [ADDR_W-1:0]    grant_addr;

    // State, starvation counter and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IfArbIdle;
            wait_cnt_q  <= '0;
            resp_word_q <= '0;
            resp_mis_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            resp_word_q <= resp_word_d;
            resp_mis_q  <= resp_mis_d;
        end
    end

    // Grant decision in IDLE, next state, counter and response capture.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        resp_word_d = resp_word_q;
        resp_mis_d  = resp_mis_q;
        grant_if    = 1'b0;
        grant_dbg   = 1'b0;
        grant_addr  = '0;

        unique case (state_q)
            IfArbIdle: begin
                if (dbg_req && (!if_req || wait_cnt_q == WaitLimitC)) begin
                    grant_dbg  = 1'b1;
                    grant_addr = dbg_addr;
                    state_d    = IfArbRespDbg;
                    wait_cnt_d = '0;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    grant_addr = if_addr;
                    state_d    = IfArbRespIf;
                    if (dbg_req && wait_cnt_q < WaitLimitC) begin
                        wait_cnt_d = wait_cnt_q + IfArbCntW'(1);
                    end
                end
                if (!dbg_req) begin
                    wait_cnt_d = '0;
                end
                if (grant_if || grant_dbg) begin
                    resp_mis_d  = is_misaligned(grant_addr[1:0]);
                    resp_word_d = resp_mis_d ? ZeroData : rom_inst;
                end
            end
            IfArbRespIf, IfArbRespDbg: begin
                state_d = IfArbIdle;
            end
            default: begin
                state_d = IfArbIdle;
            end
        endcase
    end

    // ROM port is only driven in the grant cycle and held quiet during reset.
    assign rom_ce   = ((grant_if || grant_dbg) && !rst) ? ChipEnable : ChipDisable;
    assign rom_addr = rst ? '0 : grant_addr;

    // Acks and data decode straight from the state register so reset clears them at once.
    assign if_ack   = (state_q == IfArbRespIf);
    assign dbg_ack  = (state_q == IfArbRespDbg);
    assign if_inst  = if_ack  ? resp_word_q : ZeroData;
    assign dbg_data = dbg_ack ? resp_word_q : ZeroData;
    assign misalign = (if_ack || dbg_ack) && resp_mis_q;
    assign stallreq = if_req && !if_ack;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Self-checking bench for inst_fetch_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_inst_fetch_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dbg_req;
    logic [ADDR_W-1:0] if_addr, dbg_addr;
    logic              if_ack, dbg_ack, misalign, rom_ce, stallreq;
    logic [DATA_W-1:0] if_inst, dbg_data, rom_inst;
    logic [ADDR_W-1:0] rom_addr;

    logic [31:0] rom_mem [0:63];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_inst = rom_mem[rom_addr[7:2]];

    inst_fetch_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WAIT_LIMIT(LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_ack  (if_ack),
        .if_inst (if_inst),
        .dbg_req (dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_ack (dbg_ack),
        .dbg_data(dbg_data),
        .misalign(misalign),
        .rom_ce  (rom_ce),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst),
        .stallreq(stallreq)
    );

    // Observed outputs: {rom_ce, rom_addr, if_ack, if_inst, dbg_ack, dbg_data, misalign, stallreq}
    wire [100:0] obs = {rom_ce, rom_addr, if_ack, if_inst, dbg_ack, dbg_data, misalign, stallreq};

    function automatic logic [100:0] pack(input logic ce, input logic [31:0] ra,
                                          input logic ia, input logic [31:0] ii,
                                          input logic da, input logic [31:0] dd,
                                          input logic mis, input logic st);
        return {ce, ra, ia, ii, da, dd, mis, st};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 32'h0 : rom_mem[a[7:2]];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic test_reset();
        logic [100:0] exp;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h8; dbg_req = 1'b1; dbg_addr = 32'h4;
        repeat (2) @(negedge clk);
        #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_req obs=%h exp=%h", obs, exp); end
        if_req = 1'b0; dbg_req = 1'b0;
        #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_quiet obs=%h exp=%h", obs, exp); end
        @(negedge clk); rst = 1'b0;
        #1;
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_release obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_lone_fetch();
        logic [100:0] exp;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0008;
        #1;
        exp = pack(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL lone_grant obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        exp = pack(1'b0, 32'h0, 1'b1, 32'h3401_1100, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL lone_ack obs=%h exp=%h", obs, exp); end
        @(negedge clk); if_req = 1'b0;
        #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL lone_after obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [100:0] exp;
        logic [31:0]  a;
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * (k + 3));
            @(negedge clk); if_req = 1'b1; if_addr = a;
            #1;
            exp = pack(1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL b2b_grant%0d obs=%h exp=%h", k, obs, exp); end
            @(negedge clk); #1;
            exp = pack(1'b0, 32'h0, 1'b1, word_at(a), 1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL b2b_ack%0d obs=%h exp=%h", k, obs, exp); end
        end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_starvation();
        logic [100:0] exp;
        logic         dbg_wins;
        logic [31:0]  a;
        for (int s = 0; s < 6; s++) begin
            dbg_wins = (s == int'(LIMIT));
            a = dbg_wins ? 32'h40 : 32'h20;
            @(negedge clk); if_req = 1'b1; if_addr = 32'h20; dbg_req = 1'b1; dbg_addr = 32'h40;
            #1;
            exp = pack(1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL starve_grant%0d obs=%h exp=%h", s, obs, exp); end
            @(negedge clk); #1;
            if (dbg_wins) exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, word_at(a), 1'b0, 1'b1);
            else          exp = pack(1'b0, 32'h0, 1'b1, word_at(a), 1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL starve_ack%0d obs=%h exp=%h", s, obs, exp); end
        end
        @(negedge clk); if_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [100:0] exp;
        @(negedge clk); dbg_req = 1'b1; dbg_addr = 32'h6;
        #1;
        exp = pack(1'b1, 32'h6, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL misal_grant obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL misal_ack obs=%h exp=%h", obs, exp); end
        @(negedge clk); dbg_req = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [100:0] exp;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h10;
        #1;
        exp = pack(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL arst_grant obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        exp = pack(1'b0, 32'h0, 1'b1, word_at(32'h10), 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL arst_preack obs=%h exp=%h", obs, exp); end
        #2 rst = 1'b1;
        #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL arst_drop obs=%h exp=%h", obs, exp); end
        @(negedge clk); rst = 1'b0;
        #1;
        exp = pack(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL arst_regrant obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        exp = pack(1'b0, 32'h0, 1'b1, word_at(32'h10), 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL arst_reack obs=%h exp=%h", obs, exp); end
        @(negedge clk); if_req = 1'b0;
    endtask

    task automatic test_idle();
        logic [100:0] exp;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL idle%0d obs=%h exp=%h", c, obs, exp); end
        end
        // A fresh counter means IF wins the first contested slot.
        @(negedge clk); if_req = 1'b1; if_addr = 32'h24; dbg_req = 1'b1; dbg_addr = 32'h28;
        #1;
        exp = pack(1'b1, 32'h24, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL idle_contest obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        @(negedge clk); if_req = 1'b0;
        #1;
        exp = pack(1'b1, 32'h28, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL idle_dbg_grant obs=%h exp=%h", obs, exp); end
        @(negedge clk); #1;
        exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, word_at(32'h28), 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL idle_dbg_ack obs=%h exp=%h", obs, exp); end
        @(negedge clk); dbg_req = 1'b0;
    endtask

    // Model: a port with a pending slot acks next cycle; otherwise the priority
    // rule picks a winner from the requests and the count of debug losses.
    task automatic test_random();
        logic [100:0] exp;
        logic [31:0]  gaddr, word;
        logic         mis, if_done, dbg_done;
        int           pend, lost, win;
        pend = 0; lost = 0; word = 32'h0; mis = 1'b0;
        if_done = 1'b0; dbg_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (if_done || !if_req) begin
                if_req = ($urandom_range(0, 3) != 0); if_addr = rand_addr();
            end
            if (dbg_done || !dbg_req) begin
                dbg_req = ($urandom_range(0, 2) != 0); dbg_addr = rand_addr();
            end
            if_done = 1'b0; dbg_done = 1'b0;
            #1;
            win = 0; gaddr = 32'h0;
            if (pend == 0) begin
                if (dbg_req && (!if_req || lost == int'(LIMIT))) begin win = 2; gaddr = dbg_addr; end
                else if (if_req) begin win = 1; gaddr = if_addr; end
                exp = pack(win != 0, gaddr, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, if_req);
            end else if (pend == 1) begin
                exp = pack(1'b0, 32'h0, 1'b1, word, 1'b0, 32'h0, mis, 1'b0);
                if_done = 1'b1;
            end else begin
                exp = pack(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, word, mis, if_req);
                dbg_done = 1'b1;
            end
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL random_c%0d obs=%h exp=%h", c, obs, exp); end
            if (pend == 0) begin
                if (win == 2 || !dbg_req) lost = 0;
                else if (win == 1 && lost < int'(LIMIT)) lost++;
                mis  = (gaddr[1:0] != 2'b00);
                word = word_at(gaddr);
                pend = win;
            end else begin
                pend = 0;
            end
        end
        @(negedge clk); if_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        rom_mem[2] = 32'h3401_1100;
        test_reset();
        test_lone_fetch();
        test_back_to_back();
        test_starvation();
        test_misaligned();
        test_async_reset();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_arbiter.md
# inst_fetch_arbiter

Shares the single combinational instruction ROM port between two requesters: the IF stage fetch port (high priority) and a debug/loader read port (low priority). It is a request/acknowledge arbiter with a registered response and an anti-starvation counter, and it raises a stall request toward the pipeline controller while a fetch is outstanding. It sits between `pc_reg`/IF and the instruction ROM, and drives the ROM's chip enable and address.

## Interface

Parameters:
- `ADDR_W`, 32, address width of both requesters and the ROM.
- `DATA_W`, 32, instruction word width.
- `WAIT_LIMIT`, 4, consecutive lost arbitration cycles after which the debug port wins; range 1..15.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in ADDR_W: fetch byte address; stable while `if_req` is high.
- `if_ack` out 1: one-cycle pulse; `if_inst` is valid in this cycle.
- `if_inst` out DATA_W: fetched word.
- `dbg_req` in 1: debug read request; held until `dbg_ack`.
- `dbg_addr` in ADDR_W: debug byte address.
- `dbg_ack` out 1: one-cycle pulse; `dbg_data` is valid in this cycle.
- `dbg_data` out DATA_W: read word.
- `misalign` out 1: valid with either ack; high when the served address has `addr[1:0] != 0`.
- `rom_ce` out 1: ROM chip enable; combinational, high only in the grant cycle.
- `rom_addr` out ADDR_W: ROM address; the granted requester's address, or 0 when no grant.
- `rom_inst` in DATA_W: combinational ROM read data.
- `stallreq` out 1: `if_req & ~if_ack`; goes to the pipeline controller.

## Operation

States are `IDLE`, `RESP_IF` and `RESP_DBG`.

- **IDLE:** grant is evaluated combinationally.
  - The debug port wins if `dbg_req` is high and either `if_req` is low or `wait_cnt == WAIT_LIMIT`.
  - Otherwise the IF port wins if `if_req` is high.
  - The winner's address drives `rom_addr` with `rom_ce=1`.
  - The ROM data, or 0 if misaligned, is registered into the response register together with the misalign flag. The next state is `RESP_IF` or `RESP_DBG`.
  - With no request: `rom_ce=0`, `rom_addr=0`, and the state stays `IDLE`.
- **RESP_IF / RESP_DBG:**
  - Assert the matching ack for exactly one cycle and drive the registered word onto that port's data output. Drive the other port's data output to 0.
  - No grant is made in this state; the next state is always `IDLE`.
- **Requesters:** a requester holding `req` high after its ack is making a new request, evaluated in the following `IDLE`.
- **wait_cnt** (4 bits):
  - Increments, saturating at `WAIT_LIMIT`, in each `IDLE` cycle in which `dbg_req` is high and the IF port is granted.
  - Clears when the debug port is granted, or when `dbg_req` is low in `IDLE`.
  - Holds in the response states.
- **Misaligned access:** the word is forced to 0 and `misalign=1` in the ack cycle. A misaligned access still occupies the normal two-cycle slot.

## Timing

- **Latency:** request seen in `IDLE` at cycle N, ack at N+1. Maximum throughput is one access per 2 cycles.
- **Reset values:**
  - State `IDLE`, `wait_cnt=0`, response register 0.
  - `if_ack=0`, `dbg_ack=0`, `if_inst=0`, `dbg_data=0`, `misalign=0`.
  - `rom_ce=0` and `rom_addr=0` while reset is asserted.
  - `stallreq` follows `if_req`.
- **Reset mid-operation:** any pending ack is dropped and not replayed. Requesters re-request after reset.
- **Simultaneous requests with `wait_cnt < WAIT_LIMIT`:** the IF port wins.
- **Simultaneous requests with `wait_cnt == WAIT_LIMIT`:** the debug port wins, and `stallreq` stays high for that slot.
- **Address changes:** changing the address while `req` is held is illegal. The arbiter samples the address only in the grant cycle.

## Structure

- Add to the shared `defines.v`:
  - state encodings `IfArbIdle`, `IfArbRespIf`, `IfArbRespDbg` (2 bits);
  - `IfArbWaitMax`, the default `WAIT_LIMIT`.
- Reuse the existing `ChipEnable`/`ChipDisable` and `ZeroWord` constants.
- The design is a single module with no sub-modules. The grant logic, FSM, counter and response register all fit in one file.

## Test plan

- **Lone fetch:** `if_req=1`, `if_addr=0x0000_0008`, ROM word[2]=`0x3401_1100` → cycle N `rom_ce=1`, `rom_addr=0x8`; cycle N+1 `if_ack=1`, `if_inst=0x3401_1100`, `stallreq=0`.
- **Back-to-back fetches, continuous `if_req`:** acks arrive every 2nd cycle, and `stallreq` toggles 1,0,1,0.
- **Starvation:** both requests held, `WAIT_LIMIT=4` → IF is acked 4 times, then `dbg_ack` with the correct word. `wait_cnt` returns to 0 and IF is served next.
- **Misaligned debug read:** `dbg_addr=0x6` → `dbg_ack=1`, `dbg_data=0`, `misalign=1`.
- **Async reset mid-operation:** assert `rst` in a `RESP_IF` cycle between clock edges → `if_ack` and `if_inst` go to 0 immediately. After release, an idle-grant cycle precedes the next ack.
- **Idle:** no requests for 10 cycles → `rom_ce=0`, `rom_addr=0`, no acks, `wait_cnt=0`.
